alu_mc: RTL

- Parametrised multi-cycle ALU; successor to the fixed 8-bit single-cycle ALU.
- Adds generic WIDTH, valid/ready handshakes, registered results, and iterative unsigned MUL/DIV.
- Sits between the operand/opcode issue logic and the result/flag consumer; one operation in flight at a time.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_muldiv_iter.sv | 92 +++++++++
 rtl/alu_mc.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, FSM-state and flag-index definitions for the multi-cycle ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_SAR = 4'd8;
  localparam logic [3:0] OP_ROL = 4'd9;
  localparam logic [3:0] OP_ROR = 4'd10;
  localparam logic [3:0] OP_INC = 4'd11;
  localparam logic [3:0] OP_DEC = 4'd12;
  localparam logic [3:0] OP_CMP = 4'd13;
  localparam logic [3:0] OP_MUL = 4'd14;
  localparam logic [3:0] OP_DIV = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int FLG_EQ = 0;
  localparam int FLG_GT = 1;
  localparam int FLG_LT = 2;
  localparam int FLG_Z  = 3;
  localparam int FLG_C  = 4;
  localparam int FLG_V  = 5;
  localparam int FLG_N  = 6;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// Optional ALU_MUL_EARLY_TERM_EN: multiply stops once the remaining multiplier bits are zero.
module alu_muldiv_iter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic                 busy;
  logic                 div_mode;
  logic                 last;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   prod, prod_nxt;
  logic [2*WIDTH-1:0]   mcand, mcand_nxt;
  logic [WIDTH-1:0]     mplier, mplier_nxt;
  logic [WIDTH-1:0]     quo, quo_nxt;
  logic [WIDTH-1:0]     rem, rem_nxt;
  logic [WIDTH-1:0]     dvsr;
  logic [WIDTH:0]       trial;

  // Bit W of the trial difference is set exactly when the shifted remainder is below the divisor.
  always_comb begin
    trial = {rem, quo[WIDTH-1]} - {1'b0, dvsr};
    if (!trial[WIDTH]) begin
      rem_nxt = trial[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt = {rem[WIDTH-2:0], quo[WIDTH-1]};
      quo_nxt = {quo[WIDTH-2:0], 1'b0};
    end
    prod_nxt   = mplier[0] ? (prod + mcand) : prod;
    mcand_nxt  = mcand << 1;
    mplier_nxt = mplier >> 1;
    last       = (cnt == CNT_LAST);
`ifdef ALU_MUL_EARLY_TERM_EN
    if (!div_mode && (mplier_nxt == '0)) last = 1'b1;
`endif
  end

  // Results are presented from the next-state values so the caller can register them on the final step.
  assign done   = busy && last;
  assign res_lo = div_mode ? quo_nxt : prod_nxt[WIDTH-1:0];
  assign res_hi = div_mode ? rem_nxt : prod_nxt[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      div_mode <= 1'b0;
      cnt      <= '0;
    end else if (start) begin
      busy     <= 1'b1;
      div_mode <= is_div;
      cnt      <= '0;
    end else if (busy) begin
      if (last) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      prod   <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      quo    <= a;
      rem    <= '0;
      dvsr   <= b;
    end else if (busy) begin
      prod   <= prod_nxt;
      mcand  <= mcand_nxt;
      mplier <= mplier_nxt;
      quo    <= quo_nxt;
      rem    <= rem_nxt;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU top: handshake FSM, single-cycle datapath, registered result and flags.
// MUL early termination is selected by ALU_MUL_EARLY_TERM_EN inside alu_muldiv_iter.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       S,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] F,
  output logic [WIDTH-1:0] FF,
  output logic             EQUAL,
  output logic             GT,
  output logic             LT,
  output logic             Zero,
  output logic             CarryOut,
  output logic             Overflow
);

  localparam int SH_W = $clog2(WIDTH);

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      a_p0, b_p0;
  logic [3:0]            s_p0;
  logic                  accept, is_iter, load_out, mdu_done;
  logic [WIDTH-1:0]      op_a, op_b, mdu_lo, mdu_hi;
  logic [3:0]            op_s;
  logic [WIDTH-1:0]      res_f, res_ff;
  logic [FLG_N-1:0]      res_flg;
  logic [WIDTH:0]        sum_x, dif_x, inc_x, dec_x;
  logic [2*WIDTH-1:0]    rot_l, rot_r;
  logic signed [WIDTH-1:0] sa;
  logic [SH_W-1:0]       amt;

  function automatic logic add_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic [WIDTH-1:0] r);
    return (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
  endfunction

  function automatic logic sub_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic [WIDTH-1:0] r);
    return (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
  endfunction

  assign IN_READY  = (state_q == ST_IDLE) && !RST;
  assign OUT_VALID = (state_q == ST_DONE);
  assign accept    = IN_VALID && IN_READY;
  assign is_iter   = (S == OP_MUL) || ((S == OP_DIV) && (B != '0));
  assign load_out  = (accept && !is_iter) || ((state_q == ST_CALC) && mdu_done);

  // Single-cycle ops evaluate straight from the inputs; MUL/DIV finish from the captured copy.
  assign op_a = (state_q == ST_IDLE) ? A : a_p0;
  assign op_b = (state_q == ST_IDLE) ? B : b_p0;
  assign op_s = (state_q == ST_IDLE) ? S : s_p0;

  always_ff @(posedge CLK) begin
    if (accept) begin
      a_p0 <= A;
      b_p0 <= B;
      s_p0 <= S;
    end
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (CLK),
    .rst    (RST),
    .start  (accept && is_iter),
    .is_div (S == OP_DIV),
    .a      (A),
    .b      (B),
    .done   (mdu_done),
    .res_lo (mdu_lo),
    .res_hi (mdu_hi)
  );

  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = is_iter ? ST_CALC : ST_DONE;
      ST_CALC: if (mdu_done) state_d = ST_DONE;
      ST_DONE: if (OUT_READY) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    res_f   = '0;
    res_ff  = '0;
    res_flg = '0;
    sum_x   = {1'b0, op_a} + {1'b0, op_b};
    dif_x   = {1'b0, op_a} - {1'b0, op_b};
    inc_x   = {1'b0, op_a} + (WIDTH+1)'(1);
    dec_x   = {1'b0, op_a} - (WIDTH+1)'(1);
    amt     = op_b[SH_W-1:0];
    sa      = op_a;
    rot_l   = {op_a, op_a} << amt;
    rot_r   = {op_a, op_a} >> amt;
    case (op_s)
      OP_ADD: begin
        res_f          = sum_x[WIDTH-1:0];
        res_flg[FLG_C] = sum_x[WIDTH];
        res_flg[FLG_V] = add_ovf(op_a, op_b, sum_x[WIDTH-1:0]);
      end
      OP_SUB: begin
        res_f          = dif_x[WIDTH-1:0];
        res_flg[FLG_C] = dif_x[WIDTH];
        res_flg[FLG_V] = sub_ovf(op_a, op_b, dif_x[WIDTH-1:0]);
      end
      OP_AND: res_f = op_a & op_b;
      OP_OR:  res_f = op_a | op_b;
      OP_XOR: res_f = op_a ^ op_b;
      OP_NOT: res_f = ~op_a;
      OP_SHL: res_f = op_a << amt;
      OP_SHR: res_f = op_a >> amt;
      OP_SAR: res_f = sa >>> amt;
      OP_ROL: res_f = rot_l[2*WIDTH-1:WIDTH];
      OP_ROR: res_f = rot_r[WIDTH-1:0];
      OP_INC: begin
        res_f          = inc_x[WIDTH-1:0];
        res_flg[FLG_C] = inc_x[WIDTH];
        res_flg[FLG_V] = add_ovf(op_a, WIDTH'(1), inc_x[WIDTH-1:0]);
      end
      OP_DEC: begin
        res_f          = dec_x[WIDTH-1:0];
        res_flg[FLG_C] = dec_x[WIDTH];
        res_flg[FLG_V] = sub_ovf(op_a, WIDTH'(1), dec_x[WIDTH-1:0]);
      end
      OP_CMP: begin
        res_f          = dif_x[WIDTH-1:0];
        res_flg[FLG_C] = dif_x[WIDTH];
      end
      OP_MUL: begin
        res_f          = mdu_lo;
        res_ff         = mdu_hi;
        res_flg[FLG_V] = (mdu_hi != '0);
      end
      OP_DIV: begin
        if (op_b == '0) begin
          res_f          = '1;
          res_ff         = op_a;
          res_flg[FLG_V] = 1'b1;
        end else begin
          res_f  = mdu_lo;
          res_ff = mdu_hi;
        end
      end
    endcase
    res_flg[FLG_EQ] = (op_a == op_b);
    res_flg[FLG_GT] = (op_a > op_b);
    res_flg[FLG_LT] = (op_a < op_b);
    res_flg[FLG_Z]  = (op_s == OP_MUL) ? ({res_ff, res_f} == '0) : (res_f == '0);
  end

  // Output register stage: loads only on entry to DONE, cleared by reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      F        <= '0;
      FF       <= '0;
      EQUAL    <= 1'b0;
      GT       <= 1'b0;
      LT       <= 1'b0;
      Zero     <= 1'b0;
      CarryOut <= 1'b0;
      Overflow <= 1'b0;
    end else if (load_out) begin
      F        <= res_f;
      FF       <= res_ff;
      EQUAL    <= res_flg[FLG_EQ];
      GT       <= res_flg[FLG_GT];
      LT       <= res_flg[FLG_LT];
      Zero     <= res_flg[FLG_Z];
      CarryOut <= res_flg[FLG_C];
      Overflow <= res_flg[FLG_V];
    end
  end

endmodule
